// File: rtl/mem_bus_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : mem_bus_arbiter                                              |
// | Description : Shares a single memory bus between the instruction-fetch     |
// |               and data-access ports. Data has priority, bounded by a       |
// |               starvation counter; in-flight fetches can be cancelled.      |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module mem_bus_arbiter #(
   parameter int unsigned STARVE_MAX = 4
) (
   input  logic        clk,
   input  logic        resetn,
   input  logic        ireq_valid,
   input  logic [63:0] ireq_addr,
   input  logic [3:0]  ireq_len,
   input  logic        dreq_valid,
   input  logic        dreq_write,
   input  logic [63:0] dreq_addr,
   input  logic [2:0]  dreq_size,
   input  logic [7:0]  dreq_strobe,
   input  logic [63:0] dreq_data,
   input  logic        flush_i,
   output logic        oreq_valid,
   output logic        oreq_write,
   output logic [63:0] oreq_addr,
   output logic [2:0]  oreq_size,
   output logic [3:0]  oreq_len,
   output logic [7:0]  oreq_strobe,
   output logic [63:0] oreq_data,
   input  logic        oresp_ready,
   input  logic        oresp_last,
   input  logic [63:0] oresp_data,
   output logic        iresp_ready,
   output logic        iresp_last,
   output logic [63:0] iresp_data,
   output logic        dresp_ready,
   output logic        dresp_last,
   output logic [63:0] dresp_data,
   output logic        i_wait,
   output logic        d_wait
);

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_BUSY_I  = 2'd1,
      ST_BUSY_D  = 2'd2,
      ST_DRAIN_I = 2'd3
   } state_t;

   localparam logic [3:0] C_STARVE_MAX = 4'(STARVE_MAX);

   state_t      r_state;
   state_t      w_state_nxt;
   logic [3:0]  r_starve_cnt;
   logic        r_write;
   logic [63:0] r_addr;
   logic [2:0]  r_size;
   logic [3:0]  r_len;
   logic [7:0]  r_strobe;
   logic [63:0] r_data;

   logic w_last_beat;
   logic w_fetch_req;
   logic w_force_i;
   logic w_grant_d;
   logic w_grant_i;

   // Arbitration: data wins unless the fetch has waited STARVE_MAX data grants.
   assign w_last_beat = oresp_ready & oresp_last;
   assign w_fetch_req = ireq_valid & ~flush_i;
   assign w_force_i   = w_fetch_req & (r_starve_cnt == C_STARVE_MAX);
   assign w_grant_d   = (r_state == ST_IDLE) & dreq_valid & ~w_force_i;
   assign w_grant_i   = (r_state == ST_IDLE) & w_fetch_req & ~w_grant_d;

   // State register, starvation counter and latched request fields.
   always_ff @(posedge clk) begin
      if (!resetn) begin
         r_state      <= ST_IDLE;
         r_starve_cnt <= 4'd0;
         r_write      <= 1'b0;
         r_addr       <= 64'd0;
         r_size       <= 3'd0;
         r_len        <= 4'd0;
         r_strobe     <= 8'd0;
         r_data       <= 64'd0;
      end else begin
         r_state <= w_state_nxt;
         if (w_grant_d) begin
            r_write  <= dreq_write;
            r_addr   <= dreq_addr;
            r_size   <= dreq_size;
            r_len    <= 4'd0;
            r_strobe <= dreq_strobe;
            r_data   <= dreq_data;
            if (!ireq_valid)
               r_starve_cnt <= 4'd0;
            else if (r_starve_cnt < C_STARVE_MAX)
               r_starve_cnt <= r_starve_cnt + 4'd1;
         end else if (w_grant_i) begin
            r_write      <= 1'b0;
            r_addr       <= ireq_addr;
            r_size       <= 3'd3;
            r_len        <= ireq_len;
            r_strobe     <= 8'd0;
            r_data       <= 64'd0;
            r_starve_cnt <= 4'd0;
         end
      end
   end

   // Next-state and response routing; a flush hides fetch beats from the core.
   always_comb begin
      w_state_nxt = r_state;
      oreq_valid  = 1'b0;
      iresp_ready = 1'b0;
      iresp_last  = 1'b0;
      dresp_ready = 1'b0;
      dresp_last  = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (w_grant_d)
               w_state_nxt = ST_BUSY_D;
            else if (w_grant_i)
               w_state_nxt = ST_BUSY_I;
         end
         ST_BUSY_I: begin
            oreq_valid  = 1'b1;
            iresp_ready = oresp_ready & ~flush_i;
            iresp_last  = oresp_last & ~flush_i;
            if (w_last_beat)
               w_state_nxt = ST_IDLE;
            else if (flush_i)
               w_state_nxt = ST_DRAIN_I;
         end
         ST_BUSY_D: begin
            oreq_valid  = 1'b1;
            dresp_ready = oresp_ready;
            dresp_last  = oresp_last;
            if (w_last_beat)
               w_state_nxt = ST_IDLE;
         end
         ST_DRAIN_I: begin
            oreq_valid = 1'b1;
            if (w_last_beat)
               w_state_nxt = ST_IDLE;
         end
         default: w_state_nxt = ST_IDLE;
      endcase
   end

   assign oreq_write  = r_write;
   assign oreq_addr   = r_addr;
   assign oreq_size   = r_size;
   assign oreq_len    = r_len;
   assign oreq_strobe = r_strobe;
   assign oreq_data   = r_data;

   assign iresp_data = iresp_ready ? oresp_data : 64'd0;
   assign dresp_data = dresp_ready ? oresp_data : 64'd0;

   // Stalls drop in the same cycle the final beat is delivered.
   assign i_wait = ireq_valid & ~(iresp_ready & iresp_last);
   assign d_wait = dreq_valid & ~(dresp_ready & dresp_last);

endmodule
`default_nettype wire

// File: tb/tb_mem_bus_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_mem_bus_arbiter                                           |
// | Description : Directed scoreboard bench for mem_bus_arbiter.               |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_mem_bus_arbiter;

   localparam bit P_I = 1'b0;
   localparam bit P_D = 1'b1;

   logic        clk = 1'b0;
   logic        resetn;
   logic        ireq_valid;
   logic [63:0] ireq_addr;
   logic [3:0]  ireq_len;
   logic        dreq_valid;
   logic        dreq_write;
   logic [63:0] dreq_addr;
   logic [2:0]  dreq_size;
   logic [7:0]  dreq_strobe;
   logic [63:0] dreq_data;
   logic        flush_i;
   logic        oreq_valid, oreq_write;
   logic [63:0] oreq_addr, oreq_data;
   logic [2:0]  oreq_size;
   logic [3:0]  oreq_len;
   logic [7:0]  oreq_strobe;
   logic        oresp_ready, oresp_last;
   logic [63:0] oresp_data;
   logic        iresp_ready, iresp_last, dresp_ready, dresp_last;
   logic [63:0] iresp_data, dresp_data;
   logic        i_wait, d_wait;

   typedef struct {
      bit          port;
      logic [63:0] data;
      logic        last;
   } exp_t;

   exp_t sb[$];
   int   n_vec = 0;
   int   n_err = 0;

   mem_bus_arbiter #(.STARVE_MAX(4)) dut (
      .clk(clk), .resetn(resetn),
      .ireq_valid(ireq_valid), .ireq_addr(ireq_addr), .ireq_len(ireq_len),
      .dreq_valid(dreq_valid), .dreq_write(dreq_write), .dreq_addr(dreq_addr),
      .dreq_size(dreq_size), .dreq_strobe(dreq_strobe), .dreq_data(dreq_data),
      .flush_i(flush_i),
      .oreq_valid(oreq_valid), .oreq_write(oreq_write), .oreq_addr(oreq_addr),
      .oreq_size(oreq_size), .oreq_len(oreq_len), .oreq_strobe(oreq_strobe),
      .oreq_data(oreq_data),
      .oresp_ready(oresp_ready), .oresp_last(oresp_last), .oresp_data(oresp_data),
      .iresp_ready(iresp_ready), .iresp_last(iresp_last), .iresp_data(iresp_data),
      .dresp_ready(dresp_ready), .dresp_last(dresp_last), .dresp_data(dresp_data),
      .i_wait(i_wait), .d_wait(d_wait)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_vec++;
      assert (obs === exp)
      else begin
         n_err++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Response monitor: every forwarded beat must match the next scoreboard entry.
   always @(negedge clk) begin
      if (iresp_ready || dresp_ready) begin
         if (iresp_ready && dresp_ready) begin
            chk("both_ports_ready", {iresp_ready, dresp_ready}, 64'd1);
         end else if (sb.size() == 0) begin
            chk("unexpected_beat", 64'd1, 64'd0);
         end else begin
            exp_t e;
            e = sb.pop_front();
            chk("beat_port", {63'd0, dresp_ready}, {63'd0, e.port});
            if (e.port == P_I) begin
               chk("ibeat_data", iresp_data, e.data);
               chk("ibeat_last", {63'd0, iresp_last}, {63'd0, e.last});
            end else begin
               chk("dbeat_data", dresp_data, e.data);
               chk("dbeat_last", {63'd0, dresp_last}, {63'd0, e.last});
            end
         end
      end
   end

   // Bus model: nwait idle cycles then nbeats beats; a fetch flushed at beat
   // flush_at hides that and every later beat, and the fetch is withdrawn.
   task automatic xfer(input bit port, input int nwait, input int nbeats,
                       input logic [63:0] base, input int flush_at);
      for (int w = 0; w < nwait; w++) begin
         oresp_ready = 1'b0;
         oresp_last  = 1'b0;
         tick();
      end
      for (int k = 0; k < nbeats; k++) begin
         bit hidden;
         hidden      = (port == P_I) && (flush_at >= 0) && (k >= flush_at);
         oresp_ready = 1'b1;
         oresp_last  = (k == nbeats - 1);
         oresp_data  = base + 64'(k);
         flush_i     = (port == P_I) && (k == flush_at);
         if (!hidden)
            sb.push_back('{port, base + 64'(k), (k == nbeats - 1)});
         #1;
         chk("xfer_oreq_valid", {63'd0, oreq_valid}, 64'd1);
         if (hidden)
            chk("flushed_iresp_ready", {63'd0, iresp_ready}, 64'd0);
         if ((k == nbeats - 1) && !hidden) begin
            if (port == P_I) chk("i_wait_last", {63'd0, i_wait}, 64'd0);
            else             chk("d_wait_last", {63'd0, d_wait}, 64'd0);
         end
         tick();
         if (k == flush_at && port == P_I) begin
            flush_i    = 1'b0;
            ireq_valid = 1'b0;
         end
      end
      oresp_ready = 1'b0;
      oresp_last  = 1'b0;
      oresp_data  = 64'd0;
      flush_i     = 1'b0;
   endtask

   initial begin
      resetn = 1'b0; ireq_valid = 1'b0; ireq_addr = 64'd0; ireq_len = 4'd0;
      dreq_valid = 1'b0; dreq_write = 1'b0; dreq_addr = 64'd0; dreq_size = 3'd0;
      dreq_strobe = 8'd0; dreq_data = 64'd0; flush_i = 1'b0;
      oresp_ready = 1'b0; oresp_last = 1'b0; oresp_data = 64'd0;
      tick(); tick();
      resetn = 1'b1;
      #1;
      chk("rst_oreq_valid", {63'd0, oreq_valid}, 64'd0);
      chk("rst_oreq_addr", oreq_addr, 64'd0);
      chk("rst_oreq_len", {60'd0, oreq_len}, 64'd0);
      chk("rst_starve", {60'd0, dut.r_starve_cnt}, 64'd0);
      chk("rst_i_wait", {63'd0, i_wait}, 64'd0);

      // Lone fetch: 4 beats after 2 wait cycles.
      ireq_valid = 1'b1; ireq_addr = 64'h8000_0000; ireq_len = 4'd3;
      #1;
      chk("s1_i_wait", {63'd0, i_wait}, 64'd1);
      chk("s1_cycle0_valid", {63'd0, oreq_valid}, 64'd0);
      tick();
      chk("s1_oreq_valid", {63'd0, oreq_valid}, 64'd1);
      chk("s1_oreq_addr", oreq_addr, 64'h8000_0000);
      chk("s1_oreq_len", {60'd0, oreq_len}, 64'd3);
      chk("s1_oreq_size", {61'd0, oreq_size}, 64'd3);
      chk("s1_oreq_write", {63'd0, oreq_write}, 64'd0);
      xfer(P_I, 2, 4, 64'hA000, -1);
      ireq_valid = 1'b0;
      chk("s1_idle_after", {63'd0, oreq_valid}, 64'd0);
      chk("s1_sb_empty", 64'(sb.size()), 64'd0);

      // Simultaneous requests: data first, then fetch after one idle cycle.
      ireq_valid = 1'b1; ireq_addr = 64'h1000; ireq_len = 4'd1;
      dreq_valid = 1'b1; dreq_write = 1'b0; dreq_addr = 64'h2000; dreq_size = 3'd2;
      tick();
      chk("s2_d_addr", oreq_addr, 64'h2000);
      chk("s2_d_len", {60'd0, oreq_len}, 64'd0);
      chk("s2_d_size", {61'd0, oreq_size}, 64'd2);
      chk("s2_starve1", {60'd0, dut.r_starve_cnt}, 64'd1);
      xfer(P_D, 0, 1, 64'hD000, -1);
      dreq_valid = 1'b0;
      chk("s2_gap", {63'd0, oreq_valid}, 64'd0);
      tick();
      chk("s2_i_addr", oreq_addr, 64'h1000);
      chk("s2_i_len", {60'd0, oreq_len}, 64'd1);
      chk("s2_starve0", {60'd0, dut.r_starve_cnt}, 64'd0);
      xfer(P_I, 1, 2, 64'hB000, -1);
      ireq_valid = 1'b0;
      chk("s2_sb_empty", 64'(sb.size()), 64'd0);

      // Back-to-back stores with a held fetch: 4 data grants, then the fetch.
      ireq_valid = 1'b1; ireq_addr = 64'h3000; ireq_len = 4'd0;
      dreq_valid = 1'b1; dreq_write = 1'b1; dreq_size = 3'd3;
      for (int n = 0; n < 4; n++) begin
         dreq_addr = 64'h100 + 64'(8 * n); dreq_strobe = 8'hF0 | 8'(n);
         dreq_data = 64'hCAFE_0000 + 64'(n);
         tick();
         chk("s3_d_write", {63'd0, oreq_write}, 64'd1);
         chk("s3_d_addr", oreq_addr, 64'h100 + 64'(8 * n));
         chk("s3_d_strobe", {56'd0, oreq_strobe}, {56'd0, 8'hF0 | 8'(n)});
         chk("s3_d_data", oreq_data, 64'hCAFE_0000 + 64'(n));
         chk("s3_starve", {60'd0, dut.r_starve_cnt}, 64'(n + 1));
         dreq_addr = 64'h0; dreq_data = 64'h0;   // oreq must stay latched
         #1;
         chk("s3_d_addr_stable", oreq_addr, 64'h100 + 64'(8 * n));
         xfer(P_D, 0, 1, 64'hE000 + 64'(n), -1);
         chk("s3_gap", {63'd0, oreq_valid}, 64'd0);
      end
      dreq_addr = 64'h200; dreq_strobe = 8'h0F; dreq_data = 64'h55;
      tick();
      chk("s3_forced_i_addr", oreq_addr, 64'h3000);
      chk("s3_forced_i_write", {63'd0, oreq_write}, 64'd0);
      chk("s3_forced_i_strobe", {56'd0, oreq_strobe}, 64'd0);
      chk("s3_forced_i_data", oreq_data, 64'd0);
      chk("s3_starve_clr", {60'd0, dut.r_starve_cnt}, 64'd0);
      xfer(P_I, 0, 1, 64'hF000, -1);
      ireq_valid = 1'b0;
      tick();
      chk("s3_last_d_addr", oreq_addr, 64'h200);
      chk("s3_starve_noi", {60'd0, dut.r_starve_cnt}, 64'd0);
      xfer(P_D, 0, 1, 64'hE100, -1);
      dreq_valid = 1'b0; dreq_write = 1'b0; dreq_strobe = 8'd0;
      chk("s3_sb_empty", 64'(sb.size()), 64'd0);

      // Flush on the 2nd of 4 fetch beats: remaining beats drained silently.
      ireq_valid = 1'b1; ireq_addr = 64'h4000; ireq_len = 4'd3;
      tick();
      chk("s4_valid", {63'd0, oreq_valid}, 64'd1);
      xfer(P_I, 0, 4, 64'h4400, 1);
      chk("s4_idle_after", {63'd0, oreq_valid}, 64'd0);
      chk("s4_sb_empty", 64'(sb.size()), 64'd0);

      // Flush coincident with the last fetch beat while data waits.
      ireq_valid = 1'b1; ireq_addr = 64'h5000; ireq_len = 4'd1;
      tick();
      dreq_valid = 1'b1; dreq_addr = 64'h5800; dreq_size = 3'd3;
      #1;
      chk("s5_d_wait", {63'd0, d_wait}, 64'd1);
      chk("s5_i_addr", oreq_addr, 64'h5000);
      xfer(P_I, 0, 2, 64'h5500, 1);
      chk("s5_idle", {63'd0, oreq_valid}, 64'd0);
      tick();
      chk("s5_d_addr", oreq_addr, 64'h5800);
      xfer(P_D, 0, 1, 64'h5900, -1);
      dreq_valid = 1'b0;
      chk("s5_sb_empty", 64'(sb.size()), 64'd0);

      // Reset in the middle of a data transaction.
      dreq_valid = 1'b1; dreq_write = 1'b1; dreq_addr = 64'h6000;
      dreq_strobe = 8'hFF; dreq_data = 64'h1234;
      tick();
      chk("s6_busy_d", {63'd0, oreq_valid}, 64'd1);
      tick();
      resetn = 1'b0; dreq_valid = 1'b0;
      tick();
      chk("s6_rst_valid", {63'd0, oreq_valid}, 64'd0);
      chk("s6_rst_write", {63'd0, oreq_write}, 64'd0);
      chk("s6_rst_addr", oreq_addr, 64'd0);
      chk("s6_rst_data", oreq_data, 64'd0);
      chk("s6_rst_strobe", {56'd0, oreq_strobe}, 64'd0);
      chk("s6_rst_size", {61'd0, oreq_size}, 64'd0);
      chk("s6_rst_resp", {60'd0, iresp_ready, iresp_last, dresp_ready, dresp_last}, 64'd0);
      resetn = 1'b1; dreq_write = 1'b0; dreq_strobe = 8'd0;
      ireq_valid = 1'b1; ireq_addr = 64'h7000; ireq_len = 4'd0;
      tick();
      chk("s6_i_valid", {63'd0, oreq_valid}, 64'd1);
      chk("s6_i_addr", oreq_addr, 64'h7000);
      xfer(P_I, 0, 1, 64'h7700, -1);
      ireq_valid = 1'b0;
      tick();
      chk("s6_sb_empty", 64'(sb.size()), 64'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/mem_bus_arbiter.md
# mem_bus_arbiter

Two-requester memory arbiter sharing the core's single memory bus between the instruction-fetch port and the data-access port. It grants one transaction at a time and holds the grant until the bus signals the last beat. Data requests have priority, with a starvation limit that guarantees fetch progress. It produces the `i_wait`/`d_wait` stall inputs consumed by the hazard unit and supports cancellation of an in-flight fetch on redirect (branch/mret).

## Interface
Parameters:
- `STARVE_MAX`, 4: consecutive data grants allowed while a fetch is pending before the fetch is forced through (1..15).

Ports:
- `clk`  in  1  core clock
- `resetn`  in  1  synchronous, active-low reset
- `ireq_valid`  in  1  fetch request pending
- `ireq_addr`  in  64  fetch address
- `ireq_len`  in  4  fetch burst beats minus 1
- `dreq_valid`  in  1  data request pending
- `dreq_write`  in  1  1 = store
- `dreq_addr`  in  64  data address
- `dreq_size`  in  3  access size (log2 bytes)
- `dreq_strobe`  in  8  byte enables (store)
- `dreq_data`  in  64  store data
- `flush_i`  in  1  cancel current/pending fetch (redirect)
- `oreq_valid`, `oreq_write`  out  1 each  bus request
- `oreq_addr`  out  64; `oreq_size`  out  3; `oreq_len`  out  4; `oreq_strobe`  out  8; `oreq_data`  out  64
- `oresp_ready`, `oresp_last`  in  1 each; `oresp_data`  in  64  bus response beat
- `iresp_ready`, `iresp_last`  out  1 each; `iresp_data`  out  64  fetch response
- `dresp_ready`, `dresp_last`  out  1 each; `dresp_data`  out  64  data response
- `i_wait`, `d_wait`  out  1 each  stall requests to hazard unit

## Operation
- States: IDLE, BUSY_I, BUSY_D, DRAIN_I.
- IDLE grant rule, evaluated each cycle:
  - Data is granted if `dreq_valid`, unless `ireq_valid & ~flush_i & starve_cnt==STARVE_MAX`; in that case fetch is granted.
  - Otherwise fetch is granted if `ireq_valid & ~flush_i`.
  - With no grant, stay in IDLE.
- On grant, request fields are latched into registers. `oreq_*` are driven only from these registers.
  - Fetch grant: `oreq_write=0`, `oreq_size=3`, `oreq_strobe=0`, `oreq_data=0`.
  - Data grant: `oreq_len=0`.
- `starve_cnt` (4 bits):
  - On a data grant while `ireq_valid`: +1, saturating at `STARVE_MAX`.
  - On a fetch grant, or a data grant with `ireq_valid=0`: cleared to 0.
- BUSY_x: `oreq_valid=1`. `oresp_ready`/`oresp_last`/`oresp_data` pass through combinationally to the granted port; the other port's ready/last stay 0.
  - On `oresp_ready & oresp_last` → IDLE.
- BUSY_I with `flush_i` (and no last beat that cycle) → DRAIN_I.
  - DRAIN_I keeps `oreq_valid=1` and the latched fields, and forces `iresp_ready=iresp_last=0`.
  - On last beat → IDLE.
- BUSY_I with `flush_i` and last beat in the same cycle: the response is suppressed (`iresp_ready=0`) and the next state is IDLE.
- `iresp_ready` is also masked in BUSY_I during any cycle with `flush_i=1`.
- `i_wait = ireq_valid & ~(iresp_ready & iresp_last)`; `d_wait = dreq_valid & ~(dresp_ready & dresp_last)`.
- Requester contract: valid and fields are held until the last beat is returned. Only fetch may withdraw (after `flush_i`). Withdrawal does not abort the bus transaction.
- `resp_data` outputs are `oresp_data` when the port's ready is 1, else 0.

## Timing
- Reset (`resetn=0` at a rising edge):
  - state → IDLE, `starve_cnt` → 0, latched fields → 0.
  - All `oreq_*`, `iresp_*` and `dresp_*` outputs read 0.
  - This applies mid-transaction too; the bus is reset in the same cycle.
- Grant latency:
  - A request seen in IDLE at edge t produces `oreq_valid=1` from t+1.
  - Response beats are forwarded in the same cycle (0 latency).
- The last beat in cycle k gives IDLE at k+1 (`oreq_valid=0`). The next grant is evaluated in cycle k+1, so `oreq_valid` rises at k+2: exactly one idle bus cycle between transactions.
- `oreq_*` are stable for the whole transaction, independent of requester input changes.
- `i_wait`/`d_wait` are combinational: they drop in the cycle the last beat is delivered and are never 1 while the corresponding valid is 0.

## Test plan
- Lone fetch, `ireq_addr=0x8000_0000`, `ireq_len=3`, bus returns 4 beats after 2 wait cycles → `oreq_valid` from cycle 1, `oreq_len=3`, `iresp_last` on beat 4, `i_wait` low in that cycle; `dresp_*` stay 0.
- `ireq_valid` and `dreq_valid` asserted in the same cycle → data granted first; fetch granted one cycle after data's last beat; `starve_cnt` goes 1 then 0.
- Continuous back-to-back data stores with `ireq_valid` held, `STARVE_MAX=4` → 4 data transactions, then the fetch is granted on the 5th arbitration; the counter clears.
- `flush_i` pulsed on the 2nd of 4 fetch beats, fetch valid dropped → beats 2–4 not visible on `iresp_ready`; `oreq_valid` held until the bus last beat; IDLE next cycle.
- `flush_i` coincident with the last fetch beat, `dreq_valid` pending → `iresp_ready=0`; data granted in the following IDLE cycle.
- `resetn=0` mid-BUSY_D → next cycle all outputs 0, state IDLE; after release with `ireq_valid=1`, fetch is granted normally.
